// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer that lends one combinational ALU to two requesters,
// holds operands for ALU_LAT cycles, then returns the tagged result.
module alu_share_ctrl #(
  parameter int ALU_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0_VALID,
  output logic        REQ0_READY,
  input  logic [31:0] REQ0_RS1_DATA,
  input  logic [31:0] REQ0_RS2_DATA,
  input  logic [31:0] REQ0_PC,
  input  logic [19:0] REQ0_U_IMM20,
  input  logic [4:0]  REQ0_RS2,
  input  logic [11:0] REQ0_IMM12,
  input  logic [6:0]  REQ0_OPCODE,
  input  logic [2:0]  REQ0_FUNCT3,
  input  logic        REQ0_FUNCT1,
  input  logic        REQ1_VALID,
  output logic        REQ1_READY,
  input  logic [31:0] REQ1_RS1_DATA,
  input  logic [31:0] REQ1_RS2_DATA,
  input  logic [31:0] REQ1_PC,
  input  logic [19:0] REQ1_U_IMM20,
  input  logic [4:0]  REQ1_RS2,
  input  logic [11:0] REQ1_IMM12,
  input  logic [6:0]  REQ1_OPCODE,
  input  logic [2:0]  REQ1_FUNCT3,
  input  logic        REQ1_FUNCT1,
  output logic [31:0] ALU_RS1_DATA,
  output logic [31:0] ALU_RS2_DATA,
  output logic [31:0] ALU_PC,
  output logic [19:0] ALU_U_IMM20,
  output logic [4:0]  ALU_RS2,
  output logic [11:0] ALU_IMM12,
  output logic [6:0]  ALU_OPCODE,
  output logic [2:0]  ALU_FUNCT3,
  output logic        ALU_FUNCT1,
  input  logic [31:0] ALU_OUT,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic        RSP_ID,
  output logic [31:0] RSP_DATA,
  output logic [1:0]  FLAG_REG
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam int         BW = 144;
  localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

  logic [1:0]    state_reg;
  logic          last_reg;
  logic [3:0]    cnt_reg;
  logic [BW-1:0] op_reg;
  logic [31:0]   rsp_data_reg;
  logic          rsp_id_reg;
  logic [1:0]    flag_reg;

  logic [BW-1:0] bundle [2];
  logic [1:0]    req_valid;
  logic [1:0]    grant;
  logic          idle;

  assign bundle[0] = {REQ0_RS1_DATA, REQ0_RS2_DATA, REQ0_PC, REQ0_U_IMM20, REQ0_RS2,
                      REQ0_IMM12, REQ0_OPCODE, REQ0_FUNCT3, REQ0_FUNCT1};
  assign bundle[1] = {REQ1_RS1_DATA, REQ1_RS2_DATA, REQ1_PC, REQ1_U_IMM20, REQ1_RS2,
                      REQ1_IMM12, REQ1_OPCODE, REQ1_FUNCT3, REQ1_FUNCT1};
  assign req_valid = {REQ1_VALID, REQ0_VALID};
  assign idle      = (state_reg == ST_IDLE) && !RST;

  // A requester wins if it is alone, or on a tie when it was not granted last.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_grant
      assign grant[gi] = idle && req_valid[gi] &&
                         (!req_valid[1-gi] || (last_reg != 1'(gi)));
    end
  endgenerate

  assign REQ0_READY = grant[0];
  assign REQ1_READY = grant[1];
  assign RSP_VALID  = (state_reg == ST_RESP) && !RST;
  assign RSP_ID     = rsp_id_reg;
  assign RSP_DATA   = rsp_data_reg;
  assign FLAG_REG   = flag_reg;
  assign {ALU_RS1_DATA, ALU_RS2_DATA, ALU_PC, ALU_U_IMM20, ALU_RS2,
          ALU_IMM12, ALU_OPCODE, ALU_FUNCT3, ALU_FUNCT1} = op_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= ST_IDLE;
      last_reg     <= 1'b1;
      cnt_reg      <= 4'd0;
      op_reg       <= '0;
      rsp_data_reg <= 32'd0;
      rsp_id_reg   <= 1'b0;
      flag_reg     <= 2'b00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|grant) begin
            op_reg     <= grant[1] ? bundle[1] : bundle[0];
            rsp_id_reg <= grant[1];
            last_reg   <= grant[1];
            cnt_reg    <= 4'd0;
            state_reg  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == LAT_LAST) begin
            rsp_data_reg <= ALU_OUT;
            flag_reg     <= {ALU_OUT[31], ALU_OUT == 32'd0};
            state_reg    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (RSP_READY) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench: two controllers (ALU_LAT 1 and 4) share the request stimulus,
// each drives its own behavioural ALU.
module tb_alu_share_ctrl;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  logic clk = 1'b0;
  logic rst, rsp_ready;
  logic req0_valid, req0_funct1, req1_valid, req1_funct1;
  logic [31:0] req0_rs1_data, req0_rs2_data, req0_pc, req1_rs1_data, req1_rs2_data, req1_pc;
  logic [19:0] req0_u_imm20, req1_u_imm20;
  logic [4:0]  req0_rs2, req1_rs2;
  logic [11:0] req0_imm12, req1_imm12;
  logic [6:0]  req0_opcode, req1_opcode;
  logic [2:0]  req0_funct3, req1_funct3;

  logic a_req0_ready, a_req1_ready, a_alu_funct1, a_rsp_valid, a_rsp_id;
  logic [31:0] a_alu_rs1_data, a_alu_rs2_data, a_alu_pc, a_alu_out, a_rsp_data;
  logic [19:0] a_alu_u_imm20;
  logic [4:0]  a_alu_rs2;
  logic [11:0] a_alu_imm12;
  logic [6:0]  a_alu_opcode;
  logic [2:0]  a_alu_funct3;
  logic [1:0]  a_flag;

  logic b_req0_ready, b_req1_ready, b_alu_funct1, b_rsp_valid, b_rsp_id;
  logic [31:0] b_alu_rs1_data, b_alu_rs2_data, b_alu_pc, b_alu_out, b_rsp_data;
  logic [19:0] b_alu_u_imm20;
  logic [4:0]  b_alu_rs2;
  logic [11:0] b_alu_imm12;
  logic [6:0]  b_alu_opcode;
  logic [2:0]  b_alu_funct3;
  logic [1:0]  b_flag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [31:0] rs1, rs2, pc,
      input logic [19:0] u, input logic [4:0] sh, input logic [11:0] imm,
      input logic [6:0] op, input logic [2:0] f3, input logic f1);
    if (op == OP_IMM && f3 == 3'b000) return rs1 + {{20{imm[11]}}, imm};
    if (op == OP_IMM && f3 == 3'b001) return rs1 << sh;
    if (op == OP_REG && f3 == 3'b000) return f1 ? rs1 - rs2 : rs1 + rs2;
    if (op == 7'b0010111) return pc + {u, 12'h000};
    if (op == 7'b0110111) return {u, 12'h000};
    return 32'd0;
  endfunction

  assign a_alu_out = alu_model(a_alu_rs1_data, a_alu_rs2_data, a_alu_pc, a_alu_u_imm20,
                               a_alu_rs2, a_alu_imm12, a_alu_opcode, a_alu_funct3, a_alu_funct1);
  assign b_alu_out = alu_model(b_alu_rs1_data, b_alu_rs2_data, b_alu_pc, b_alu_u_imm20,
                               b_alu_rs2, b_alu_imm12, b_alu_opcode, b_alu_funct3, b_alu_funct1);

  alu_share_ctrl #(.ALU_LAT(1)) u_dut_a (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(req0_valid), .REQ0_READY(a_req0_ready), .REQ0_RS1_DATA(req0_rs1_data),
    .REQ0_RS2_DATA(req0_rs2_data), .REQ0_PC(req0_pc), .REQ0_U_IMM20(req0_u_imm20),
    .REQ0_RS2(req0_rs2), .REQ0_IMM12(req0_imm12), .REQ0_OPCODE(req0_opcode),
    .REQ0_FUNCT3(req0_funct3), .REQ0_FUNCT1(req0_funct1),
    .REQ1_VALID(req1_valid), .REQ1_READY(a_req1_ready), .REQ1_RS1_DATA(req1_rs1_data),
    .REQ1_RS2_DATA(req1_rs2_data), .REQ1_PC(req1_pc), .REQ1_U_IMM20(req1_u_imm20),
    .REQ1_RS2(req1_rs2), .REQ1_IMM12(req1_imm12), .REQ1_OPCODE(req1_opcode),
    .REQ1_FUNCT3(req1_funct3), .REQ1_FUNCT1(req1_funct1),
    .ALU_RS1_DATA(a_alu_rs1_data), .ALU_RS2_DATA(a_alu_rs2_data), .ALU_PC(a_alu_pc),
    .ALU_U_IMM20(a_alu_u_imm20), .ALU_RS2(a_alu_rs2), .ALU_IMM12(a_alu_imm12),
    .ALU_OPCODE(a_alu_opcode), .ALU_FUNCT3(a_alu_funct3), .ALU_FUNCT1(a_alu_funct1),
    .ALU_OUT(a_alu_out), .RSP_VALID(a_rsp_valid), .RSP_READY(rsp_ready),
    .RSP_ID(a_rsp_id), .RSP_DATA(a_rsp_data), .FLAG_REG(a_flag)
  );

  alu_share_ctrl #(.ALU_LAT(4)) u_dut_b (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(req0_valid), .REQ0_READY(b_req0_ready), .REQ0_RS1_DATA(req0_rs1_data),
    .REQ0_RS2_DATA(req0_rs2_data), .REQ0_PC(req0_pc), .REQ0_U_IMM20(req0_u_imm20),
    .REQ0_RS2(req0_rs2), .REQ0_IMM12(req0_imm12), .REQ0_OPCODE(req0_opcode),
    .REQ0_FUNCT3(req0_funct3), .REQ0_FUNCT1(req0_funct1),
    .REQ1_VALID(req1_valid), .REQ1_READY(b_req1_ready), .REQ1_RS1_DATA(req1_rs1_data),
    .REQ1_RS2_DATA(req1_rs2_data), .REQ1_PC(req1_pc), .REQ1_U_IMM20(req1_u_imm20),
    .REQ1_RS2(req1_rs2), .REQ1_IMM12(req1_imm12), .REQ1_OPCODE(req1_opcode),
    .REQ1_FUNCT3(req1_funct3), .REQ1_FUNCT1(req1_funct1),
    .ALU_RS1_DATA(b_alu_rs1_data), .ALU_RS2_DATA(b_alu_rs2_data), .ALU_PC(b_alu_pc),
    .ALU_U_IMM20(b_alu_u_imm20), .ALU_RS2(b_alu_rs2), .ALU_IMM12(b_alu_imm12),
    .ALU_OPCODE(b_alu_opcode), .ALU_FUNCT3(b_alu_funct3), .ALU_FUNCT1(b_alu_funct1),
    .ALU_OUT(b_alu_out), .RSP_VALID(b_rsp_valid), .RSP_READY(rsp_ready),
    .RSP_ID(b_rsp_id), .RSP_DATA(b_rsp_data), .FLAG_REG(b_flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end else begin
      $display("ok   %s %h", tag, obs);
    end
  endtask

  // Each cycle: inputs change 1 time unit after the rising edge, outputs are read 2 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit id, input bit v, input logic [31:0] rs1, rs2,
      input logic [11:0] imm, input logic [6:0] op, input logic [2:0] f3, input bit f1);
    if (!id) begin
      req0_valid = v; req0_rs1_data = rs1; req0_rs2_data = rs2; req0_imm12 = imm;
      req0_opcode = op; req0_funct3 = f3; req0_funct1 = f1;
    end else begin
      req1_valid = v; req1_rs1_data = rs1; req1_rs2_data = rs2; req1_imm12 = imm;
      req1_opcode = op; req1_funct3 = f3; req1_funct1 = f1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  // Single operation on the ALU_LAT=1 controller with RSP_READY high.
  task automatic issue_a(input bit id, input logic [31:0] rs1, rs2, input logic [11:0] imm,
      input logic [6:0] op, input logic [2:0] f3, input bit f1,
      input logic [31:0] exp_data, input logic [1:0] exp_flag, input string tag);
    drive_req(id, 1'b1, rs1, rs2, imm, op, f3, f1);
    #2;
    check({tag, "_ready"}, id ? a_req1_ready : a_req0_ready, 32'd1);
    next_cycle();
    if (!id) req0_valid = 1'b0; else req1_valid = 1'b0;
    #2;
    check({tag, "_exec_valid"}, a_rsp_valid, 32'd0);
    check({tag, "_alu_rs1"}, a_alu_rs1_data, rs1);
    check({tag, "_alu_pc"}, a_alu_pc, id ? 32'h2000 : 32'h1000);
    next_cycle();
    #2;
    check({tag, "_rsp_valid"}, a_rsp_valid, 32'd1);
    check({tag, "_rsp_data"}, a_rsp_data, exp_data);
    check({tag, "_rsp_id"}, a_rsp_id, 32'(id));
    check({tag, "_flag"}, a_flag, 32'(exp_flag));
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, 12'd0, 7'd0, 3'd0, 1'b0);
    drive_req(1'b1, 1'b0, 32'd0, 32'd0, 12'd0, 7'd0, 3'd0, 1'b0);
    req0_pc = 32'h1000; req1_pc = 32'h2000;
    req0_u_imm20 = 20'h12345; req1_u_imm20 = 20'h0abcd;
    req0_rs2 = 5'd3; req1_rs2 = 5'd4;
    next_cycle();
    next_cycle();

    // Reset state, with a request already pending
    drive_req(1'b0, 1'b1, 32'd5, 32'd0, 12'd7, OP_IMM, 3'b000, 1'b0);
    #2;
    check("rst_req0_ready", a_req0_ready, 32'd0);
    check("rst_rsp_valid", a_rsp_valid, 32'd0);
    check("rst_alu_rs1", a_alu_rs1_data, 32'd0);
    check("rst_alu_opcode", a_alu_opcode, 32'd0);
    check("rst_rsp_data", a_rsp_data, 32'd0);
    check("rst_rsp_id", a_rsp_id, 32'd0);
    check("rst_flag", a_flag, 32'd0);
    rst = 1'b0;
    issue_a(1'b0, 32'd5, 32'd0, 12'd7, OP_IMM, 3'b000, 1'b0, 32'd12, 2'b00, "addi");

    // Both valid: grants alternate 0,1,0,1 with one response per 3 cycles
    do_reset();
    drive_req(1'b0, 1'b1, 32'd10, 32'd20, 12'd0, OP_REG, 3'b000, 1'b0);
    drive_req(1'b1, 1'b1, 32'd100, 32'd1, 12'd0, OP_REG, 3'b000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #2;
      check($sformatf("rr%0d_ready0", i), a_req0_ready, 32'(i % 2 == 0));
      check($sformatf("rr%0d_ready1", i), a_req1_ready, 32'(i % 2 == 1));
      next_cycle();
      #2;
      check($sformatf("rr%0d_exec_valid", i), a_rsp_valid, 32'd0);
      next_cycle();
      #2;
      check($sformatf("rr%0d_rsp_valid", i), a_rsp_valid, 32'd1);
      check($sformatf("rr%0d_rsp_id", i), a_rsp_id, 32'(i % 2));
      check($sformatf("rr%0d_rsp_data", i), a_rsp_data, (i % 2 == 1) ? 32'd99 : 32'd30);
      check($sformatf("rr%0d_no_ready", i), 32'(a_req0_ready | a_req1_ready), 32'd0);
      next_cycle();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    next_cycle();

    // SUB flag cases on requester 1
    issue_a(1'b1, 32'd3, 32'd3, 12'd0, OP_REG, 3'b000, 1'b1, 32'd0, 2'b01, "sub_zero");
    issue_a(1'b1, 32'd1, 32'd2, 12'd0, OP_REG, 3'b000, 1'b1, 32'hFFFF_FFFF, 2'b10, "sub_neg");

    // Back-pressure: response held for 10 cycles with both requesters pending
    rsp_ready = 1'b0;
    drive_req(1'b0, 1'b1, 32'h10, 32'd0, 12'hFFF, OP_IMM, 3'b000, 1'b0);
    #2;
    check("bp_ready0", a_req0_ready, 32'd1);
    next_cycle();
    drive_req(1'b1, 1'b1, 32'd50, 32'd60, 12'd0, OP_REG, 3'b000, 1'b0);
    #2;
    check("bp_exec_valid", a_rsp_valid, 32'd0);
    next_cycle();
    for (int k = 0; k < 10; k++) begin
      #2;
      check($sformatf("bp%0d_rsp_valid", k), a_rsp_valid, 32'd1);
      check($sformatf("bp%0d_rsp_data", k), a_rsp_data, 32'h0000_000F);
      check($sformatf("bp%0d_alu_rs1", k), a_alu_rs1_data, 32'h10);
      check($sformatf("bp%0d_no_ready", k), 32'(a_req0_ready | a_req1_ready), 32'd0);
      next_cycle();
    end
    rsp_ready = 1'b1;
    #2;
    check("bp_release_valid", a_rsp_valid, 32'd1);
    next_cycle();
    #2;
    check("bp_after_valid", a_rsp_valid, 32'd0);
    check("bp_after_ready1", a_req1_ready, 32'd1);
    check("bp_after_ready0", a_req0_ready, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    next_cycle();

    // ALU_LAT=4: operands stable T+1..T+5, response in T+5
    do_reset();
    drive_req(1'b0, 1'b1, 32'd7, 32'd8, 12'd0, OP_REG, 3'b000, 1'b0);
    #2;
    check("lat4_ready0", b_req0_ready, 32'd1);
    next_cycle();
    req0_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #2;
      check($sformatf("lat4_t%0d_alu_rs1", k), b_alu_rs1_data, 32'd7);
      check($sformatf("lat4_t%0d_rsp_valid", k), b_rsp_valid, 32'd0);
      next_cycle();
    end
    #2;
    check("lat4_t5_rsp_valid", b_rsp_valid, 32'd1);
    check("lat4_t5_rsp_data", b_rsp_data, 32'd15);
    check("lat4_t5_rsp_id", b_rsp_id, 32'd0);
    check("lat4_t5_alu_rs1", b_alu_rs1_data, 32'd7);
    next_cycle();

    // ALU_LAT=4 with reset in T+2: result discarded
    drive_req(1'b0, 1'b1, 32'd9, 32'd9, 12'd0, OP_REG, 3'b000, 1'b0);
    #2;
    check("abort_ready0", b_req0_ready, 32'd1);
    next_cycle();
    req0_valid = 1'b0;
    #2;
    check("abort_t1_alu_rs1", b_alu_rs1_data, 32'd9);
    next_cycle();
    rst = 1'b1;
    #2;
    check("abort_t2_rsp_valid", b_rsp_valid, 32'd0);
    next_cycle();
    rst = 1'b0;
    #2;
    check("abort_t3_alu_rs1", b_alu_rs1_data, 32'd0);
    check("abort_t3_rsp_data", b_rsp_data, 32'd0);
    check("abort_t3_flag", b_flag, 32'd0);
    check("abort_t3_rsp_valid", b_rsp_valid, 32'd0);
    for (int k = 4; k <= 7; k++) begin
      next_cycle();
      #2;
      check($sformatf("abort_t%0d_rsp_valid", k), b_rsp_valid, 32'd0);
    end
    next_cycle();
    drive_req(1'b1, 1'b1, 32'h100, 32'd0, 12'h800, OP_IMM, 3'b000, 1'b0);
    #2;
    check("post_ready1", b_req1_ready, 32'd1);
    next_cycle();
    req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) next_cycle();
    #2;
    check("post_rsp_valid", b_rsp_valid, 32'd1);
    check("post_rsp_data", b_rsp_data, 32'hFFFF_F900);
    check("post_rsp_id", b_rsp_id, 32'd1);
    check("post_flag", b_flag, 32'(2'b10));
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
